// File: rtl/signal_sequencer.sv
// signal_sequencer: plays a 16-entry step table into signal_generator's cfg/amplitude inputs.
// Optional build macro SIGNAL_SEQUENCER_RAMP_EN: amplitudes slew by RAMP_STEP per cycle instead of jumping.
module signal_sequencer #(
    parameter int CFG_DATA_WIDTH  = 32,
    parameter int AMPLITUDE_WIDTH = 16,
    parameter int STEP_ADDR_WIDTH = 4,
    parameter int DURATION_WIDTH  = 32,
    parameter int REPEAT_WIDTH    = 16,
    parameter int RAMP_STEP       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [STEP_ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]                 wr_cfg,
    input  logic [AMPLITUDE_WIDTH-1:0] wr_amplitude_A,
    input  logic [AMPLITUDE_WIDTH-1:0] wr_amplitude_B,
    input  logic [DURATION_WIDTH-1:0]  wr_duration,
    input  logic [STEP_ADDR_WIDTH:0]   num_steps,
    input  logic [REPEAT_WIDTH-1:0]    num_repeats,
    input  logic                       trigger,
    input  logic                       stop,
    output logic [CFG_DATA_WIDTH-1:0]  cfg_data,
    output logic [AMPLITUDE_WIDTH-1:0] amplitude_A,
    output logic [AMPLITUDE_WIDTH-1:0] amplitude_B,
    output logic [STEP_ADDR_WIDTH-1:0] step_index,
    output logic                       busy,
    output logic                       step_strobe,
    output logic                       done
);

    localparam int DEPTH = 1 << STEP_ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [7:0]                 IDLE_CFG = 8'h09;
    localparam logic [DURATION_WIDTH-1:0]  DUR_ONE  = DURATION_WIDTH'(1);
    localparam logic [REPEAT_WIDTH-1:0]    REP_ONE  = REPEAT_WIDTH'(1);
    localparam logic [STEP_ADDR_WIDTH:0]   STEP_ONE = (STEP_ADDR_WIDTH+1)'(1);
    localparam logic [AMPLITUDE_WIDTH-1:0] AMP_STEP = AMPLITUDE_WIDTH'(RAMP_STEP);

    logic [7:0]                 tbl_cfg   [DEPTH];
    logic [AMPLITUDE_WIDTH-1:0] tbl_amp_a [DEPTH];
    logic [AMPLITUDE_WIDTH-1:0] tbl_amp_b [DEPTH];
    logic [DURATION_WIDTH-1:0]  tbl_dur   [DEPTH];

    logic [1:0]                 state;
    logic [STEP_ADDR_WIDTH-1:0] ptr;
    logic [STEP_ADDR_WIDTH:0]   steps_q;
    logic [STEP_ADDR_WIDTH:0]   steps_last;
    logic [DURATION_WIDTH-1:0]  dur_cnt;
    logic [DURATION_WIDTH-1:0]  dur_load;
    logic [REPEAT_WIDTH-1:0]    rep_cnt;
    logic [7:0]                 cfg_q;
    logic                       is_last;

    logic [7:0]                 rd_cfg;
    logic [AMPLITUDE_WIDTH-1:0] rd_amp_a;
    logic [AMPLITUDE_WIDTH-1:0] rd_amp_b;
    logic [DURATION_WIDTH-1:0]  rd_dur;

    // Move cur toward tgt by at most AMP_STEP, landing exactly on tgt.
    function automatic logic [AMPLITUDE_WIDTH-1:0] slew(input logic [AMPLITUDE_WIDTH-1:0] cur,
                                                          input logic [AMPLITUDE_WIDTH-1:0] tgt);
        logic [AMPLITUDE_WIDTH-1:0] res;
        res = tgt;
        if (cur < tgt && (tgt - cur) > AMP_STEP)
            res = cur + AMP_STEP;
        else if (cur > tgt && (cur - tgt) > AMP_STEP)
            res = cur - AMP_STEP;
        return res;
    endfunction

    // The table has no reset so its contents survive reset; it only accepts writes while idle.
    always_ff @(posedge clk) begin
        if (wr_en && state == ST_IDLE) begin
            tbl_cfg[wr_addr]   <= wr_cfg;
            tbl_amp_a[wr_addr] <= wr_amplitude_A;
            tbl_amp_b[wr_addr] <= wr_amplitude_B;
            tbl_dur[wr_addr]   <= wr_duration;
        end
    end

    assign rd_cfg     = tbl_cfg[ptr];
    assign rd_amp_a   = tbl_amp_a[ptr];
    assign rd_amp_b   = tbl_amp_b[ptr];
    assign rd_dur     = tbl_dur[ptr];
    assign dur_load   = (rd_dur == '0) ? DUR_ONE : rd_dur;
    assign steps_last = steps_q - STEP_ONE;
    assign is_last    = ({1'b0, ptr} == steps_last);
    assign cfg_data   = {{(CFG_DATA_WIDTH-8){1'b0}}, cfg_q};

`ifdef SIGNAL_SEQUENCER_RAMP_EN
    logic [AMPLITUDE_WIDTH-1:0] tgt_a;
    logic [AMPLITUDE_WIDTH-1:0] tgt_b;
    logic [AMPLITUDE_WIDTH-1:0] slew_a;
    logic [AMPLITUDE_WIDTH-1:0] slew_b;
    logic                       draining;

    assign slew_a = slew(amplitude_A, tgt_a);
    assign slew_b = slew(amplitude_B, tgt_b);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            steps_q     <= '0;
            dur_cnt     <= '0;
            rep_cnt     <= '0;
            cfg_q       <= IDLE_CFG;
            amplitude_A <= '0;
            amplitude_B <= '0;
            step_index  <= '0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
`ifdef SIGNAL_SEQUENCER_RAMP_EN
            tgt_a       <= '0;
            tgt_b       <= '0;
            draining    <= 1'b0;
`endif
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
`ifdef SIGNAL_SEQUENCER_RAMP_EN
            amplitude_A <= slew_a;
            amplitude_B <= slew_b;
`endif
            if (stop) begin
                state       <= ST_IDLE;
                ptr         <= '0;
                dur_cnt     <= '0;
                cfg_q       <= IDLE_CFG;
                amplitude_A <= '0;
                amplitude_B <= '0;
                step_index  <= '0;
                busy        <= 1'b0;
`ifdef SIGNAL_SEQUENCER_RAMP_EN
                tgt_a       <= '0;
                tgt_b       <= '0;
                draining    <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trigger && num_steps != '0) begin
                            state   <= ST_LOAD;
                            busy    <= 1'b1;
                            steps_q <= num_steps;
                            rep_cnt <= num_repeats;
                            ptr     <= '0;
                        end
                    end
                    ST_LOAD: begin
                        state       <= ST_RUN;
                        dur_cnt     <= dur_load;
                        cfg_q       <= rd_cfg;
                        step_index  <= ptr;
                        step_strobe <= 1'b1;
`ifdef SIGNAL_SEQUENCER_RAMP_EN
                        tgt_a       <= rd_amp_a;
                        tgt_b       <= rd_amp_b;
                        amplitude_A <= slew(amplitude_A, rd_amp_a);
                        amplitude_B <= slew(amplitude_B, rd_amp_b);
`else
                        amplitude_A <= rd_amp_a;
                        amplitude_B <= rd_amp_b;
`endif
                    end
                    ST_RUN: begin
`ifdef SIGNAL_SEQUENCER_RAMP_EN
                        // After the last entry, stay busy until both amplitudes have ramped to zero.
                        if (draining) begin
                            if (slew_a == '0 && slew_b == '0) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                draining <= 1'b0;
                            end
                        end else
`endif
                        if (dur_cnt != DUR_ONE) begin
                            dur_cnt <= dur_cnt - DUR_ONE;
                        end else if (!is_last) begin
                            ptr   <= ptr + 1'b1;
                            state <= ST_LOAD;
                        end else if (rep_cnt != REP_ONE) begin
                            // A repeat count of zero means endless: wrap without counting.
                            ptr   <= '0;
                            state <= ST_LOAD;
                            if (rep_cnt != '0)
                                rep_cnt <= rep_cnt - REP_ONE;
                        end else begin
                            cfg_q      <= IDLE_CFG;
                            step_index <= '0;
`ifdef SIGNAL_SEQUENCER_RAMP_EN
                            tgt_a      <= '0;
                            tgt_b      <= '0;
                            draining   <= 1'b1;
`else
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            amplitude_A <= '0;
                            amplitude_B <= '0;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signal_sequencer.sv
// tb_signal_sequencer: timeline reference model of the step sequencer compared every cycle,
// plus hand-computed timing and value checks for the directed scenarios.
module tb_signal_sequencer;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_cfg;
    logic [15:0] wr_amplitude_A;
    logic [15:0] wr_amplitude_B;
    logic [31:0] wr_duration;
    logic [4:0]  num_steps;
    logic [15:0] num_repeats;
    logic        trigger;
    logic        stop;
    logic [31:0] cfg_data;
    logic [15:0] amplitude_A;
    logic [15:0] amplitude_B;
    logic [3:0]  step_index;
    logic        busy;
    logic        step_strobe;
    logic        done;

    signal_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_cfg         (wr_cfg),
        .wr_amplitude_A (wr_amplitude_A),
        .wr_amplitude_B (wr_amplitude_B),
        .wr_duration    (wr_duration),
        .num_steps      (num_steps),
        .num_repeats    (num_repeats),
        .trigger        (trigger),
        .stop           (stop),
        .cfg_data       (cfg_data),
        .amplitude_A    (amplitude_A),
        .amplitude_B    (amplitude_B),
        .step_index     (step_index),
        .busy           (busy),
        .step_strobe    (step_strobe),
        .done           (done)
    );

    typedef struct packed {
        logic [31:0] cfg;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  idx;
        logic        busy;
        logic        strobe;
        logic        done;
    } rec_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } chk_t;

    rec_t        cur;
    rec_t        exp_q [$];
    chk_t        pend [$];
    logic [7:0]  sh_cfg [16];
    logic [15:0] sh_a   [16];
    logic [15:0] sh_b   [16];
    int          sh_dur [16];
    logic        check_en = 1'b0;
    int          tests = 0;
    int          failed = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic rec_t mk(input logic [31:0] c, input logic [15:0] a, input logic [15:0] b,
                                input int idx, input logic bz, input logic st, input logic dn);
        rec_t r;
        r.cfg    = c;
        r.a      = a;
        r.b      = b;
        r.idx    = 4'(idx);
        r.busy   = bz;
        r.strobe = st;
        r.done   = dn;
        return r;
    endfunction

    // Expand a whole run into one expected output record per cycle, starting at the LOAD cycle.
    task automatic buildRun(input int steps, input int reps);
        int passes;
        int d;
        passes = (reps == 0) ? 1000 : reps;
        exp_q.delete();
        exp_q.push_back(mk(32'h9, 16'h0, 16'h0, 0, 1'b1, 1'b0, 1'b0));
        for (int p = 0; p < passes && exp_q.size() < 3000; p++) begin
            for (int i = 0; i < steps; i++) begin
                d = (sh_dur[i] < 1) ? 1 : sh_dur[i];
                for (int c = 0; c < d; c++)
                    exp_q.push_back(mk({24'h0, sh_cfg[i]}, sh_a[i], sh_b[i], i, 1'b1, (c == 0), 1'b0));
                if (p == passes - 1 && i == steps - 1)
                    exp_q.push_back(mk(32'h9, 16'h0, 16'h0, 0, 1'b0, 1'b0, 1'b1));
                else
                    exp_q.push_back(mk({24'h0, sh_cfg[i]}, sh_a[i], sh_b[i], i, 1'b1, 1'b0, 1'b0));
            end
        end
    endtask

    // Reference model: cur holds the expected outputs for the cycle after each edge.
    always @(posedge clk) begin : model
        if (!reset && wr_en && !cur.busy) begin
            sh_cfg[wr_addr] <= wr_cfg;
            sh_a[wr_addr]   <= wr_amplitude_A;
            sh_b[wr_addr]   <= wr_amplitude_B;
            sh_dur[wr_addr] <= int'(wr_duration);
        end
        if (reset || stop) begin
            exp_q.delete();
            cur <= mk(32'h9, 16'h0, 16'h0, 0, 1'b0, 1'b0, 1'b0);
        end else if (!cur.busy && trigger && num_steps != 5'd0) begin
            buildRun(int'(num_steps), int'(num_repeats));
            cur <= exp_q.pop_front();
        end else if (exp_q.size() > 0) begin
            cur <= exp_q.pop_front();
        end else begin
            cur <= mk(32'h9, 16'h0, 16'h0, 0, 1'b0, 1'b0, 1'b0);
        end
    end

    always @(negedge clk) begin : compare
        chk_t c;
        if (check_en) begin
            tests++;
            if (cfg_data !== cur.cfg || amplitude_A !== cur.a || amplitude_B !== cur.b ||
                step_index !== cur.idx || busy !== cur.busy || step_strobe !== cur.strobe ||
                done !== cur.done) begin
                failed++;
                $display("[TB] FAIL cycle_compare t=%0t got cfg=%h a=%h b=%h idx=%0d busy=%b strobe=%b done=%b want cfg=%h a=%h b=%h idx=%0d busy=%b strobe=%b done=%b",
                         $time, cfg_data, amplitude_A, amplitude_B, step_index, busy, step_strobe, done,
                         cur.cfg, cur.a, cur.b, cur.idx, cur.busy, cur.strobe, cur.done);
            end
        end
        while (pend.size() > 0) begin
            c = pend.pop_front();
            tests++;
            if (c.act !== c.exp) begin
                failed++;
                $display("[TB] FAIL %s got %0h want %0h", c.name, c.act, c.exp);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        pend.push_back(c);
    endtask

    // Drive trigger/stop for one cycle; called and returns at a falling edge.
    task automatic applyStimulus(input logic trig, input logic stp);
        trigger = trig;
        stop    = stp;
        @(negedge clk);
        trigger = 1'b0;
        stop    = 1'b0;
    endtask

    task automatic writeEntry(input logic [3:0] addr, input logic [7:0] cfg, input logic [15:0] a,
                              input logic [15:0] b, input logic [31:0] dur);
        wr_en          = 1'b1;
        wr_addr        = addr;
        wr_cfg         = cfg;
        wr_amplitude_A = a;
        wr_amplitude_B = b;
        wr_duration    = dur;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // sel 0: step_strobe, 1: done, 2: busy low. n = cycles waited, -1 on timeout.
    task automatic waitFor(input int sel, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if ((sel == 0 && step_strobe) || (sel == 1 && done) || (sel == 2 && !busy)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int strobes;
        int dones;
        int busy_cnt;
        logic finished;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_cfg = '0; wr_amplitude_A = '0;
        wr_amplitude_B = '0; wr_duration = '0; num_steps = '0; num_repeats = '0;
        trigger = 1'b0; stop = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_cfg", cfg_data, 64'h9);
        checkOutput("reset_amp_a", amplitude_A, 64'h0);
        checkOutput("reset_busy", busy, 64'h0);
        checkOutput("reset_index", step_index, 64'h0);

        writeEntry(4'd0, 8'h00, 16'h1000, 16'h2000, 32'd4);
        writeEntry(4'd1, 8'h09, 16'h0800, 16'h0400, 32'd2);

        // Basic single pass
        num_steps = 5'd2; num_repeats = 16'd1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("load_busy", busy, 64'h1);
        waitFor(0, 10, n);
        checkOutput("first_strobe_latency", 64'(n + 1), 64'd2);
        checkOutput("first_entry_amp_a", amplitude_A, 64'h1000);
        checkOutput("first_entry_cfg", cfg_data, 64'h0);
        waitFor(1, 20, n);
        checkOutput("run_length", 64'(n), 64'd7);
        checkOutput("done_cfg", cfg_data, 64'h9);
        checkOutput("done_amp_a", amplitude_A, 64'h0);
        checkOutput("done_busy", busy, 64'h0);

        // Three passes
        num_repeats = 16'd3;
        applyStimulus(1'b1, 1'b0);
        strobes = 0; dones = 0;
        repeat (40) begin
            @(negedge clk);
            strobes += int'(step_strobe);
            dones   += int'(done);
        end
        checkOutput("repeat3_strobes", 64'(strobes), 64'd6);
        checkOutput("repeat3_dones", 64'(dones), 64'd1);

        // Endless, then stop
        num_repeats = 16'd0;
        applyStimulus(1'b1, 1'b0);
        dones = 0;
        repeat (100) begin
            @(negedge clk);
            dones += int'(done);
        end
        checkOutput("endless_no_done", 64'(dones), 64'd0);
        checkOutput("endless_busy", busy, 64'h1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("stop_busy", busy, 64'h0);
        checkOutput("stop_cfg", cfg_data, 64'h9);
        checkOutput("stop_no_done", done, 64'h0);

        // Zero-duration entry is held one cycle
        writeEntry(4'd2, 8'h12, 16'h0333, 16'h0111, 32'd0);
        num_steps = 5'd3; num_repeats = 16'd1;
        applyStimulus(1'b1, 1'b0);
        waitFor(0, 10, n);
        waitFor(1, 30, n);
        checkOutput("zero_dur_run_length", 64'(n), 64'd9);

        // Abort during entry 1
        num_steps = 5'd2;
        applyStimulus(1'b1, 1'b0);
        waitFor(0, 10, n);
        waitFor(0, 10, n);
        checkOutput("entry1_strobe_gap", 64'(n), 64'd5);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", busy, 64'h0);
        checkOutput("abort_amp_a", amplitude_A, 64'h0);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            dones += int'(done);
        end
        checkOutput("abort_no_done", 64'(dones), 64'd0);

        // Stop and trigger together while idle
        applyStimulus(1'b1, 1'b1);
        checkOutput("stop_trigger_idle", busy, 64'h0);

        // Writes during a run are ignored
        applyStimulus(1'b1, 1'b0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_cfg = 8'hff; wr_amplitude_A = 16'hdead;
        wr_amplitude_B = 16'hbeef; wr_duration = 32'd3;
        repeat (2) @(negedge clk);
        wr_en = 1'b0;
        waitFor(1, 30, n);
        applyStimulus(1'b1, 1'b0);
        waitFor(0, 10, n);
        checkOutput("table_unchanged_amp", amplitude_A, 64'h1000);
        checkOutput("table_unchanged_cfg", cfg_data, 64'h0);
        waitFor(1, 30, n);

        // Trigger with zero steps does nothing
        num_steps = 5'd0;
        applyStimulus(1'b1, 1'b0);
        busy_cnt = 0;
        repeat (5) begin
            busy_cnt += int'(busy);
            @(negedge clk);
        end
        checkOutput("zero_steps_idle", 64'(busy_cnt), 64'd0);

        // Reset mid-run, table survives
        num_steps = 5'd2;
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrun_reset_busy", busy, 64'h0);
        checkOutput("midrun_reset_cfg", cfg_data, 64'h9);
        applyStimulus(1'b1, 1'b0);
        waitFor(0, 10, n);
        checkOutput("table_survives_reset", amplitude_A, 64'h1000);
        waitFor(1, 30, n);

        // Randomized runs with ignored inputs toggling mid-run
        for (int it = 0; it < 15; it++) begin
            for (int e = 0; e < 16; e++)
                writeEntry(4'(e), 8'($urandom), 16'($urandom), 16'($urandom), 32'($urandom_range(0, 4)));
            num_steps   = 5'($urandom_range(1, 16));
            num_repeats = 16'($urandom_range(1, 3));
            applyStimulus(1'b1, 1'b0);
            finished = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if (!busy) begin
                    finished = 1'b1;
                    break;
                end
                trigger        = ($urandom_range(0, 7) == 0);
                stop           = ($urandom_range(0, 299) == 0);
                wr_en          = ($urandom_range(0, 3) == 0);
                wr_addr        = 4'($urandom);
                wr_cfg         = 8'($urandom);
                wr_amplitude_A = 16'($urandom);
                wr_amplitude_B = 16'($urandom);
                wr_duration    = 32'($urandom_range(0, 4));
                num_steps      = 5'($urandom_range(0, 16));
                num_repeats    = 16'($urandom);
                @(negedge clk);
            end
            trigger = 1'b0; stop = 1'b0; wr_en = 1'b0;
            checkOutput("random_run_ends", 64'(finished), 64'h1);
            if (!finished)
                applyStimulus(1'b0, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/signal_sequencer.md
# signal_sequencer

Step sequencer that drives the configuration and amplitude inputs of `signal_generator`. It holds a 16-entry step table. Each entry sets the per-channel signal type, the DAC mode, both amplitudes and a duration in samples. On trigger it plays the table, optionally a number of times, then returns to a safe idle output. It sits between the PS register interface and `signal_generator`, in the 125 MHz DAC clock domain.

## Interface
- `CFG_DATA_WIDTH`, 32, width of `cfg_data` out; bits [7:0] used, rest driven 0
- `AMPLITUDE_WIDTH`, 16, amplitude width
- `STEP_ADDR_WIDTH`, 4, table depth is 2^N entries
- `DURATION_WIDTH`, 32, step duration counter width
- `REPEAT_WIDTH`, 16, repeat counter width
- `RAMP_STEP`, 16, amplitude change per cycle (ramp build only)
- `clk`  in  1  DAC clock, 125 MHz
- `reset`  in  1  synchronous, active-high reset
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  STEP_ADDR_WIDTH  entry written
- `wr_cfg`  in  8  entry cfg byte: [2:0] type A, [5:3] type B, [6] dac_mode A, [7] dac_mode B
- `wr_amplitude_A`, `wr_amplitude_B`  in  AMPLITUDE_WIDTH  entry amplitudes
- `wr_duration`  in  DURATION_WIDTH  entry length in samples
- `num_steps`  in  STEP_ADDR_WIDTH+1  entries played, 0..2^N
- `num_repeats`  in  REPEAT_WIDTH  table passes; 0 = endless
- `trigger`  in  1  start pulse
- `stop`  in  1  abort pulse
- `cfg_data`  out  CFG_DATA_WIDTH  to `signal_generator.cfg_data`
- `amplitude_A`, `amplitude_B`  out  AMPLITUDE_WIDTH  to `signal_generator`
- `step_index`  out  STEP_ADDR_WIDTH  entry currently output
- `busy`  out  1  high in LOAD/RUN
- `step_strobe`  out  1  one-cycle pulse when a new entry reaches the outputs
- `done`  out  1  one-cycle pulse on normal completion

## Operation
- **Idle outputs:** `cfg_data`=0x09 (both channels DC), amplitudes 0, `step_index` 0.
- **Table writes:** accepted only in IDLE. `wr_en` in LOAD/RUN is ignored. Table contents survive reset (no reset on the table).
- **FSM states:** IDLE, LOAD, RUN.
- **IDLE→LOAD:** on `trigger` when `num_steps`≠0. A trigger with `num_steps`=0 is ignored.
- **In LOAD:**
  - Read entry `step_index` and load the duration counter with max(duration,1).
  - Then go to RUN, driving the outputs from the entry and pulsing `step_strobe`.
- **In RUN:** the counter decrements each cycle. At 1, the next entry is selected:
  - Index < `num_steps`−1: increment the index and go to LOAD.
  - Last entry with passes remaining, or `num_repeats`=0: index goes to 0, the repeat counter decrements (unless endless), and the FSM goes to LOAD.
  - Last entry of the last pass: go to IDLE, return the outputs to idle values, pulse `done`.
- **`stop`:** in any state, goes to IDLE next cycle with idle outputs and no `done`. `stop` and `trigger` together: stop wins.
- **Trigger rules:** `trigger` in LOAD/RUN is ignored (no retrigger).
- **Input sampling:** `num_steps` and `num_repeats` are sampled at trigger. Changes during a run have no effect.
- **`reset`:** forces IDLE and idle outputs, and clears all counters and pulses. This includes a reset mid-run.

## Timing
- **Trigger to first outputs:** `trigger` in cycle n → LOAD in n+1 → first entry on the outputs, with `step_strobe`, in n+2.
- **Entry output time:** each entry drives the outputs for exactly max(duration,1) cycles. One extra LOAD cycle follows each entry, during which the previous entry is held.
- **Run length:** total cycles from first `step_strobe` to `done` = Σ(max(d,1)+1) over all played entries, with the final LOAD replaced by the `done` cycle.
- **Output registers:** all outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`SIGNAL_SEQUENCER_RAMP_EN` defined:** amplitudes slew toward the entry target by `RAMP_STEP` per cycle, saturating at the target. `cfg_data` switches immediately. Return to idle also ramps down to 0 before `busy` falls; `stop` and `reset` still zero immediately.
- **Undefined:** amplitudes jump in the cycle of `step_strobe`.

## Test plan
- **Basic run:** write 2 entries (A: cfg 0x00, amp 0x1000, dur 4; B: cfg 0x09, amp 0x0800, dur 2), `num_steps`=2, `num_repeats`=1, trigger → first strobe at n+2, entry 0 for 4 cycles, LOAD, entry 1 for 2 cycles, then `done` and `cfg_data` 0x09 with amplitude 0.
- **Repeats:** same table, `num_repeats`=3 → exactly 6 `step_strobe` pulses and 1 `done`. With `num_repeats`=0, no `done` after 100 cycles.
- **Zero duration:** dur=0 entry → held 1 cycle.
- **Abort:** `stop` in the middle of entry 1 → idle outputs next cycle, `busy` low, no `done`. `stop`+`trigger` together in IDLE → stays idle.
- **Ignored inputs:** `wr_en` during RUN → table unchanged on the next run. `num_steps`=0 trigger → no activity.
- **Ramp build:** amp 0→0x0040 with `RAMP_STEP`=16 → 16, 32, 48, 64 over 4 cycles.
